// File: rtl/pwm_drive_arbiter_if.sv
// Drive-command bundle between the motor PWM register file / RC receiver
// (master side) and the drive arbiter (slave side).
interface pwm_drive_arbiter_if;
   logic [7:0] bus_left;
   logic [7:0] bus_right;
   logic       bus_wr;
   logic       rc_valid;
   logic [7:0] rc_left;
   logic [7:0] rc_right;
   logic [7:0] rc_switch;
   logic       pause;
   logic [7:0] width_left;
   logic [7:0] width_right;
   logic [1:0] mode;
   logic       bus_alive;
   logic       frame_tick;

   modport master (
      output bus_left, bus_right, bus_wr,
      output rc_valid, rc_left, rc_right, rc_switch,
      output pause,
      input  width_left, width_right, mode, bus_alive, frame_tick
   );

   modport slave (
      input  bus_left, bus_right, bus_wr,
      input  rc_valid, rc_left, rc_right, rc_switch,
      input  pause,
      output width_left, width_right, mode, bus_alive, frame_tick
   );
endinterface

// File: rtl/pwm_drive_arbiter.sv
// Drive arbiter for the left/right motor PWM generators. Once per frame it
// picks a width source (bus command, RC receiver or neutral), slews both
// widths toward that target by at most SLEW_STEP, and runs a frame-based
// watchdog on bus commands. Pause forces neutral on the very next edge.
//
// FRAME_CYCLES sets the frame length in clk_255kHz cycles; 5100 gives 20 ms.
//
// state        | meaning
// -------------+-------------------------------------------------------
// MODE_NEUTRAL | no live source, widths slew toward 127
// MODE_BUS     | widths slew toward the latched bus command
// MODE_RC      | widths slew toward the RC command sampled at the tick
// MODE_PAUSED  | widths held at 127; left only at the next frame tick
module pwm_drive_arbiter #(
   parameter int unsigned SLEW_STEP          = 4,
   parameter int unsigned BUS_TIMEOUT_FRAMES = 25,
   parameter int unsigned FRAME_CYCLES       = 5100
) (
   input logic                clk_255kHz,
   input logic                reset,
   pwm_drive_arbiter_if.slave drv
);

   localparam int unsigned      CNT_W      = $clog2(FRAME_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [7:0]       WDOG_LIMIT = 8'(BUS_TIMEOUT_FRAMES);
   localparam logic [8:0]       STEP9      = 9'(SLEW_STEP);
   localparam logic [7:0]       NEUTRAL_W  = 8'd127;
   localparam logic [7:0]       RC_SW_ON   = 8'd128;

   typedef enum logic [1:0] {
      MODE_NEUTRAL = 2'd0,
      MODE_BUS     = 2'd1,
      MODE_RC      = 2'd2,
      MODE_PAUSED  = 2'd3
   } mode_t;

   logic [CNT_W-1:0] count_q;
   logic             tick;
   logic [7:0]       hold_left_q;
   logic [7:0]       hold_right_q;
   logic [7:0]       hold_left_nxt;
   logic [7:0]       hold_right_nxt;
   logic [7:0]       wdog_q;
   logic [7:0]       wdog_nxt;
   logic             bus_alive_nxt;
   mode_t            mode_q;
   mode_t            mode_nxt;
   logic [7:0]       target_left;
   logic [7:0]       target_right;
   logic [7:0]       width_left_q;
   logic [7:0]       width_right_q;
   logic [7:0]       width_left_nxt;
   logic [7:0]       width_right_nxt;
   logic             frame_tick_q;

   // Move cur toward tgt by at most SLEW_STEP; 9-bit math so it cannot wrap
   // and the result never passes tgt.
   function automatic logic [7:0] slew_to(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] cur9;
      logic [8:0] tgt9;
      logic [8:0] diff;
      logic [8:0] step;
      logic [8:0] res;
      cur9 = {1'b0, cur};
      tgt9 = {1'b0, tgt};
      if (tgt9 > cur9) begin
         diff = tgt9 - cur9;
         step = (diff < STEP9) ? diff : STEP9;
         res  = cur9 + step;
      end else begin
         diff = cur9 - tgt9;
         step = (diff < STEP9) ? diff : STEP9;
         res  = cur9 - step;
      end
      slew_to = 8'(res);
   endfunction

   assign tick = (count_q == CNT_LAST);

   // Frame counter 0..FRAME_CYCLES-1; the last count is the update tick.
   always_ff @(posedge clk_255kHz) begin
      if (reset)
         count_q <= '0;
      else if (tick)
         count_q <= '0;
      else
         count_q <= count_q + 1'b1;
   end

   // A write on the tick cycle must already steer that tick, so selection
   // looks at the post-write holding value.
   always_comb begin
      hold_left_nxt  = hold_left_q;
      hold_right_nxt = hold_right_q;
      if (drv.bus_wr) begin
         hold_left_nxt  = drv.bus_left;
         hold_right_nxt = drv.bus_right;
      end
   end

   // Bus command holding registers.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         hold_left_q  <= NEUTRAL_W;
         hold_right_q <= NEUTRAL_W;
      end else begin
         hold_left_q  <= hold_left_nxt;
         hold_right_q <= hold_right_nxt;
      end
   end

   // Watchdog next value: a write clears it, ticks count up and saturate.
   always_comb begin
      wdog_nxt = wdog_q;
      if (drv.bus_wr)
         wdog_nxt = 8'd0;
      else if (tick && (wdog_q < WDOG_LIMIT))
         wdog_nxt = wdog_q + 8'd1;
      bus_alive_nxt = (wdog_nxt < WDOG_LIMIT);
   end

   // Watchdog frame count; reset leaves the bus stale until the first write.
   always_ff @(posedge clk_255kHz) begin
      if (reset)
         wdog_q <= WDOG_LIMIT;
      else
         wdog_q <= wdog_nxt;
   end

   // Source selection: pause wins on any cycle, otherwise only at the tick.
   always_comb begin
      mode_nxt = mode_q;
      if (drv.pause)
         mode_nxt = MODE_PAUSED;
      else if (tick) begin
         if (drv.rc_valid && (drv.rc_switch >= RC_SW_ON))
            mode_nxt = MODE_RC;
         else if (bus_alive_nxt)
            mode_nxt = MODE_BUS;
         else
            mode_nxt = MODE_NEUTRAL;
      end
   end

   // Mode state register.
   always_ff @(posedge clk_255kHz) begin
      if (reset)
         mode_q <= MODE_NEUTRAL;
      else
         mode_q <= mode_nxt;
   end

   // Target and slewed widths; RC inputs only matter on the tick cycle.
   always_comb begin
      target_left     = NEUTRAL_W;
      target_right    = NEUTRAL_W;
      width_left_nxt  = width_left_q;
      width_right_nxt = width_right_q;
      case (mode_nxt)
         MODE_BUS: begin
            target_left  = hold_left_nxt;
            target_right = hold_right_nxt;
         end
         MODE_RC: begin
            target_left  = drv.rc_left;
            target_right = drv.rc_right;
         end
         default: begin
            target_left  = NEUTRAL_W;
            target_right = NEUTRAL_W;
         end
      endcase
      if (drv.pause) begin
         width_left_nxt  = NEUTRAL_W;
         width_right_nxt = NEUTRAL_W;
      end else if (tick) begin
         width_left_nxt  = slew_to(width_left_q, target_left);
         width_right_nxt = slew_to(width_right_q, target_right);
      end
   end

   // Output width registers and the registered frame pulse.
   always_ff @(posedge clk_255kHz) begin
      if (reset) begin
         width_left_q  <= NEUTRAL_W;
         width_right_q <= NEUTRAL_W;
         frame_tick_q  <= 1'b0;
      end else begin
         width_left_q  <= width_left_nxt;
         width_right_q <= width_right_nxt;
         frame_tick_q  <= tick;
      end
   end

   assign drv.width_left  = width_left_q;
   assign drv.width_right = width_right_q;
   assign drv.mode        = mode_q;
   assign drv.bus_alive   = (wdog_q < WDOG_LIMIT);
   assign drv.frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_pwm_drive_arbiter.sv
// Directed bench for pwm_drive_arbiter. u_dut runs a shortened 51-cycle
// frame with default slew/timeout for the long sequencing scenarios; u_dut_d
// runs the real 5100-cycle frame with SLEW_STEP = 255 for frame timing,
// no-wrap slewing and mid-frame reset.
module tb_pwm_drive_arbiter;

   logic clk_255kHz = 1'b0;
   logic reset_m;
   logic reset_d;
   int   n_vec      = 0;
   int   n_miscomp  = 0;
   int   cyc;
   int   el;
   int   er;

   always #5 clk_255kHz = ~clk_255kHz;

   pwm_drive_arbiter_if if_m ();
   pwm_drive_arbiter_if if_d ();

   pwm_drive_arbiter #(
      .SLEW_STEP(4), .BUS_TIMEOUT_FRAMES(25), .FRAME_CYCLES(51)
   ) u_dut (
      .clk_255kHz(clk_255kHz), .reset(reset_m), .drv(if_m)
   );

   pwm_drive_arbiter #(
      .SLEW_STEP(255), .BUS_TIMEOUT_FRAMES(25), .FRAME_CYCLES(5100)
   ) u_dut_d (
      .clk_255kHz(clk_255kHz), .reset(reset_d), .drv(if_d)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscomp++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_255kHz);
      #1;
   endtask

   task automatic wait_tick(input bit dflt, input int limit, output int cycles);
      logic ft;
      cycles = 0;
      do begin
         step();
         cycles++;
         ft = dflt ? if_d.frame_tick : if_m.frame_tick;
      end while (!ft && cycles < limit);
      if (!ft) check("tick_timeout", {15'd0, ft}, 16'd1);
   endtask

   task automatic wr_m(input logic [7:0] l, input logic [7:0] r);
      if_m.bus_left  = l;
      if_m.bus_right = r;
      if_m.bus_wr    = 1'b1;
      step();
      if_m.bus_wr    = 1'b0;
   endtask

   task automatic wr_d(input logic [7:0] l, input logic [7:0] r);
      if_d.bus_left  = l;
      if_d.bus_right = r;
      if_d.bus_wr    = 1'b1;
      step();
      if_d.bus_wr    = 1'b0;
   endtask

   task automatic check_m(input string tag, input int wl, input int wr, input int md);
      check({tag, "_wl"}, if_m.width_left, 16'(wl));
      check({tag, "_wr"}, if_m.width_right, 16'(wr));
      check({tag, "_mode"}, {14'd0, if_m.mode}, 16'(md));
   endtask

   task automatic check_d(input string tag, input int wl, input int wr, input int md);
      check({tag, "_wl"}, if_d.width_left, 16'(wl));
      check({tag, "_wr"}, if_d.width_right, 16'(wr));
      check({tag, "_mode"}, {14'd0, if_d.mode}, 16'(md));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      if_m.bus_left = 8'd0; if_m.bus_right = 8'd0; if_m.bus_wr = 1'b0;
      if_m.rc_valid = 1'b0; if_m.rc_left = 8'd0; if_m.rc_right = 8'd0;
      if_m.rc_switch = 8'd0; if_m.pause = 1'b0;
      if_d.bus_left = 8'd0; if_d.bus_right = 8'd0; if_d.bus_wr = 1'b0;
      if_d.rc_valid = 1'b0; if_d.rc_left = 8'd0; if_d.rc_right = 8'd0;
      if_d.rc_switch = 8'd0; if_d.pause = 1'b0;
      reset_m = 1'b1;
      reset_d = 1'b1;
      repeat (3) step();

      check_m("rst", 127, 127, 0);
      check("rst_alive", {15'd0, if_m.bus_alive}, 16'd0);
      check("rst_ft", {15'd0, if_m.frame_tick}, 16'd0);

      // bus 200/50 written at cycle 10, then slew toward it
      reset_m = 1'b0;
      repeat (9) step();
      wr_m(8'd200, 8'd50);
      check("alive_after_wr", {15'd0, if_m.bus_alive}, 16'd1);
      wait_tick(1'b0, 200, cyc);
      check("first_tick_cyc", 16'(10 + cyc), 16'd51);
      for (int t = 1; t <= 24; t++) begin
         if (t > 1) begin
            wait_tick(1'b0, 200, cyc);
            if (t == 2) check("tick_period", 16'(cyc), 16'd51);
         end
         el = 127 + 4 * t; if (el > 200) el = 200;
         er = 127 - 4 * t; if (er < 50)  er = 50;
         check_m($sformatf("bus_t%0d", t), el, er, 1);
      end
      check("alive_t24", {15'd0, if_m.bus_alive}, 16'd1);

      // watchdog expires at tick 25; slew back to neutral over 19 ticks
      for (int k = 1; k <= 19; k++) begin
         wait_tick(1'b0, 200, cyc);
         el = 200 - 4 * k; if (el < 127) el = 127;
         er = 50 + 4 * k;  if (er > 127) er = 127;
         check_m($sformatf("expire_k%0d", k), el, er, 0);
         if (k == 1) check("alive_t25", {15'd0, if_m.bus_alive}, 16'd0);
      end

      // RC with switch below threshold stays on bus, at threshold takes over
      repeat (3) step();
      wr_m(8'd127, 8'd127);
      if_m.rc_valid = 1'b1; if_m.rc_switch = 8'd127;
      if_m.rc_left = 8'd10; if_m.rc_right = 8'd250;
      wait_tick(1'b0, 200, cyc);
      check_m("rc_sw127", 127, 127, 1);
      if_m.rc_switch = 8'd128;
      for (int k = 1; k <= 31; k++) begin
         wait_tick(1'b0, 200, cyc);
         el = 127 - 4 * k; if (el < 10)  el = 10;
         er = 127 + 4 * k; if (er > 250) er = 250;
         check_m($sformatf("rc_k%0d", k), el, er, 2);
      end

      // drive back to bus 200/50, refreshing the command each frame
      if_m.rc_valid = 1'b0; if_m.rc_switch = 8'd0;
      for (int k = 0; k < 52; k++) begin
         wait_tick(1'b0, 200, cyc);
         step();
         wr_m(8'd200, 8'd50);
      end
      check_m("pre_pause", 200, 50, 1);

      // one-cycle pause mid-frame
      repeat (5) step();
      if_m.pause = 1'b1;
      step();
      if_m.pause = 1'b0;
      check_m("pause", 127, 127, 3);
      repeat (10) step();
      check("pause_hold_mode", {14'd0, if_m.mode}, 16'd3);
      wait_tick(1'b0, 200, cyc);
      check_m("pause_exit", 131, 123, 1);

      // pause again, then bus_wr of 129/126 on the tick edge itself
      if_m.pause = 1'b1;
      step();
      if_m.pause = 1'b0;
      check_m("pause2", 127, 127, 3);
      repeat (49) step();
      if_m.bus_left = 8'd129; if_m.bus_right = 8'd126; if_m.bus_wr = 1'b1;
      step();
      if_m.bus_wr = 1'b0;
      check("coincide_ft", {15'd0, if_m.frame_tick}, 16'd1);
      check_m("coincide", 129, 126, 1);

      // watchdog restarted from 0 at that tick: expires exactly 25 ticks later
      for (int t = 1; t <= 25; t++) begin
         wait_tick(1'b0, 200, cyc);
         if (t >= 24)
            check($sformatf("wd_after_coincide_t%0d", t), {14'd0, if_m.mode},
                  (t < 25) ? 16'd1 : 16'd0);
      end

      // real frame length, SLEW_STEP = 255
      reset_d = 1'b0;
      repeat (9) step();
      wr_d(8'd255, 8'd0);
      wait_tick(1'b1, 6000, cyc);
      check("d_first_tick_cyc", 16'(10 + cyc), 16'd5100);
      check_d("d_t1", 255, 0, 1);
      repeat (9) step();
      wr_d(8'd0, 8'd255);
      wait_tick(1'b1, 6000, cyc);
      check("d_period", 16'(10 + cyc), 16'd5100);
      check_d("d_nowrap", 0, 255, 1);
      step();
      wr_d(8'd180, 8'd180);
      wait_tick(1'b1, 6000, cyc);
      check_d("d_180", 180, 180, 1);

      // reset at count 3000
      repeat (3000) step();
      reset_d = 1'b1;
      step();
      check_d("d_rst", 127, 127, 0);
      check("d_rst_alive", {15'd0, if_d.bus_alive}, 16'd0);
      check("d_rst_ft", {15'd0, if_d.frame_tick}, 16'd0);
      reset_d = 1'b0;
      wait_tick(1'b1, 6000, cyc);
      check("d_after_rst_cyc", 16'(cyc), 16'd5100);
      check_d("d_after_rst", 127, 127, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscomp);
      $finish;
   end

endmodule

// File: doc/pwm_drive_arbiter.md
# pwm_drive_arbiter

Drive-command arbiter and sequencer for the left/right motor PWM generators. Selects the width source each 20 ms frame: bus command, RC receiver, or neutral. Applies a per-frame slew limit, a bus-command watchdog and an immediate pause-to-neutral override. It sits between the motor PWM register file and the RC receiver on one side, and the two PWM generator `width` inputs on the other.

## Interface
- SLEW_STEP, 4: maximum change of each output width per frame tick, in width units (1..255).
- BUS_TIMEOUT_FRAMES, 25: number of frames without `bus_wr` before bus commands are stale (500 ms); 1..255.
- clk_255kHz  in  1  clock; one tick is 1/255 ms.
- reset  in  1  synchronous, active-high.
- bus_left  in  8  bus-commanded left width (0 = 1 ms, 255 = 2 ms, 127 = stop).
- bus_right  in  8  bus-commanded right width.
- bus_wr  in  1  one-cycle strobe, already synchronous to clk_255kHz; captures bus_left/bus_right.
- rc_valid  in  1  all required RC channels valid.
- rc_left  in  8  RC-commanded left width.
- rc_right  in  8  RC-commanded right width.
- rc_switch  in  8  RC mode-switch channel period.
- pause  in  1  level; forces neutral immediately.
- width_left  out  8  left width to the PWM generator.
- width_right  out  8  right width to the PWM generator.
- mode  out  2  active source: 0 NEUTRAL, 1 BUS, 2 RC, 3 PAUSED.
- bus_alive  out  1  bus watchdog not expired.
- frame_tick  out  1  one-cycle pulse marking a width update.

## Operation
- Frame counter counts 0..5099 and wraps to 0, giving a 20 ms frame. The internal tick is `count == 5099`.
- Holding registers capture bus_left/bus_right on any cycle where bus_wr = 1.
- Watchdog:
  - 8-bit frame count. bus_wr clears it to 0.
  - Otherwise it increments on each tick and saturates at BUS_TIMEOUT_FRAMES.
  - bus_alive = (watchdog < BUS_TIMEOUT_FRAMES).
- Source selection at each tick, in priority order:
  - pause → PAUSED
  - rc_valid && rc_switch >= 128 → RC
  - bus_alive → BUS
  - else → NEUTRAL
- Target per mode:
  - PAUSED and NEUTRAL: 127/127.
  - BUS: holding registers.
  - RC: rc_left/rc_right, sampled at the tick.
- Slew at each tick, per side, computed in 9-bit unsigned arithmetic with no wrap:
  - if target > out: out += min(SLEW_STEP, target − out)
  - else: out −= min(SLEW_STEP, out − target)
  - Outputs never overshoot the target and never leave 0..255.
- Pause override:
  - On any cycle with pause = 1, the next edge sets width_left = width_right = 127 and mode = 3, bypassing slew and the tick.
  - After pause deasserts, mode stays 3 until the next tick. Selection then resumes and outputs slew away from 127.
- Source changes (BUS↔RC, →NEUTRAL) are always slew-limited. There is no step jump except on pause.

## Timing
- Reset values: count = 0, watchdog = BUS_TIMEOUT_FRAMES, bus_alive = 0, holding registers = 127, width_left = width_right = 127, mode = 0, frame_tick = 0.
- The first tick occurs at the 5100th cycle after reset deasserts. Tick period is exactly 5100 cycles.
- frame_tick is registered. It is high for the one cycle after the tick edge, which is also the first cycle showing the new widths and mode.
- bus_wr to target latency:
  - The captured value is used at the next tick.
  - If bus_wr and the tick coincide, the new value is used and the watchdog clears to 0 rather than incrementing.
- Watchdog expiry:
  - With no bus_wr after the watchdog clears, it reaches BUS_TIMEOUT_FRAMES at the 25th tick (default).
  - That tick already selects NEUTRAL, since bus_alive is evaluated on the updated count.
- Pause latency: one cycle, independent of frame position.
- Reset mid-frame or mid-slew restores all reset values at the next edge. Holding registers return to 127.
- The rc_* inputs are sampled only at the tick. Changes between ticks have no effect.

## Test plan
- Reset, then bus_wr with 200/50 at cycle 10 → mode = 1 at the first tick. Left steps 131, 135, …, reaching 200 at tick 19. Right steps 123, …, reaching 50 at tick 20.
- Bus at steady 200/50, no further bus_wr → mode = 1 through tick 24 after the last write. mode = 0 at tick 25, after which both outputs slew 4/frame back to 127 (200 → 127 takes 19 ticks).
- rc_valid = 1, rc_switch = 128, rc = 10/250, while bus is alive at 127 → mode = 2. Outputs go 123/131, …, reaching 10/250. With rc_switch = 127, mode stays 1.
- Outputs at 200/50 mid-frame, pause pulse for 1 cycle → the next cycle shows 127/127 and mode = 3. mode holds 3 until the next tick, then returns to 1 and slews 131/123.
- bus_wr of 255/0 coinciding with the tick edge → that tick uses 255/0 (131/123) and the watchdog reads 0. Separately, with SLEW_STEP = 255 and target 0 from 255, the next tick shows 0, not a wrapped value.
- Assert reset at count 3000 with outputs at 180 → all outputs return to their reset values. The next tick comes 5100 cycles after reset deasserts.
